i2c_master_controller: RTL and testbench

- Clocked I2C bus master. Runs one complete transfer on the open-drain SDA/SCL pair: START, 7-bit address plus R/W, four data bytes MSB-first with an ACK slot after each byte, then STOP.
- Sits directly upstream of i2c_slave_controller (address 7'b0101010) and drives its 32-bit read and write transactions.
- Host side is a simple start/busy/done handshake.

---
 rtl/i2c_master_controller.sv | 194 +++++++++++++++++++
 tb/tb_i2c_master_controller.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_controller.sv
// Single-transfer I2C bus master: START, address+R/W, four data bytes with ACK slots, STOP.
// SCL is generated in quarter periods of CLK_DIV clocks; both lines are open drain.
module i2c_master_controller #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        rw,
    input  logic [6:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        ack_err,
    inout  wire         sda,
    inout  wire         scl
);

    localparam int DIV_W = $clog2(CLK_DIV);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_DATA, S_DATA_ACK, S_STOP, S_DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [DIV_W-1:0]  div_reg, div_next;
    logic [1:0]        qtr_reg, qtr_next;
    logic [2:0]        bit_reg, bit_next;
    logic [1:0]        byte_reg, byte_next;
    logic              ack_err_reg, ack_err_next;
    logic [6:0]        addr_reg;
    logic              rw_reg;
    logic [31:0]       wdata_reg;
    logic [31:0]       rx_reg;
    logic [31:0]       rdata_reg;
    logic              sample_reg;
    logic              accept, load_rdata, sda_low, scl_low;
    logic              quarter_end, slot_end, sample_now;
    logic [7:0]        addr_byte;

    assign quarter_end = (div_reg == DIV_W'(CLK_DIV - 1));
    assign slot_end    = quarter_end && (qtr_reg == 2'd3);
    assign sample_now  = quarter_end && (qtr_reg == 2'd2);
    assign addr_byte   = {addr_reg, rw_reg};

    assign sda     = sda_low ? 1'b0 : 1'bz;
    assign scl     = scl_low ? 1'b0 : 1'bz;
    assign rdata   = rdata_reg;
    assign ack_err = ack_err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            div_reg     <= '0;
            qtr_reg     <= '0;
            bit_reg     <= '0;
            byte_reg    <= '0;
            ack_err_reg <= 1'b0;
            addr_reg    <= '0;
            rw_reg      <= 1'b0;
            wdata_reg   <= '0;
            rx_reg      <= '0;
            rdata_reg   <= '0;
            sample_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            div_reg     <= div_next;
            qtr_reg     <= qtr_next;
            bit_reg     <= bit_next;
            byte_reg    <= byte_next;
            ack_err_reg <= ack_err_next;
            if (accept) begin
                addr_reg  <= addr;
                rw_reg    <= rw;
                wdata_reg <= wdata;
            end
            if (sample_now) begin
                sample_reg <= sda;
            end
            if (sample_now && state_reg == S_DATA && rw_reg) begin
                rx_reg <= {rx_reg[30:0], sda};
            end
            if (load_rdata) begin
                rdata_reg <= rx_reg;
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        div_next     = quarter_end ? '0 : div_reg + 1'b1;
        qtr_next     = quarter_end ? qtr_reg + 2'd1 : qtr_reg;
        bit_next     = bit_reg;
        byte_next    = byte_reg;
        ack_err_next = ack_err_reg;
        accept       = 1'b0;
        load_rdata   = 1'b0;
        sda_low      = 1'b0;
        scl_low      = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        case (state_reg)
            S_IDLE: begin
                busy     = 1'b0;
                div_next = '0;
                qtr_next = '0;
                if (start) begin
                    accept       = 1'b1;
                    ack_err_next = 1'b0;
                    state_next   = S_START;
                end
            end
            S_START: begin
                sda_low = qtr_reg[0];
                if (quarter_end && qtr_reg == 2'd1) begin
                    state_next = S_ADDR;
                    qtr_next   = '0;
                    bit_next   = '0;
                end
            end
            S_ADDR: begin
                scl_low = !qtr_reg[1];
                sda_low = !addr_byte[~bit_reg];
                if (slot_end) begin
                    bit_next = bit_reg + 3'd1;
                    if (bit_reg == 3'd7) state_next = S_ADDR_ACK;
                end
            end
            S_ADDR_ACK: begin
                scl_low = !qtr_reg[1];
                if (slot_end) begin
                    if (sample_reg) begin
                        ack_err_next = 1'b1;
                        state_next   = S_STOP;
                    end else begin
                        state_next = S_DATA;
                        bit_next   = '0;
                        byte_next  = '0;
                    end
                end
            end
            S_DATA: begin
                // byte_reg counts 0..3 for bytes 3..0, so the bit index is ~{byte,bit}
                scl_low = !qtr_reg[1];
                sda_low = !rw_reg && !wdata_reg[~{byte_reg, bit_reg}];
                if (slot_end) begin
                    bit_next = bit_reg + 3'd1;
                    if (bit_reg == 3'd7) state_next = S_DATA_ACK;
                end
            end
            S_DATA_ACK: begin
                scl_low = !qtr_reg[1];
                if (slot_end) begin
                    if (!rw_reg && sample_reg) begin
                        ack_err_next = 1'b1;
                        state_next   = S_STOP;
                    end else if (byte_reg == 2'd3) begin
                        state_next = S_STOP;
                    end else begin
                        byte_next  = byte_reg + 2'd1;
                        state_next = S_DATA;
                    end
                end
            end
            S_STOP: begin
                scl_low = (qtr_reg == 2'd0);
                sda_low = (qtr_reg != 2'd2);
                if (quarter_end && qtr_reg == 2'd2) begin
                    state_next = S_DONE;
                    qtr_next   = '0;
                    load_rdata = rw_reg && !ack_err_reg;
                end
            end
            S_DONE: begin
                busy       = 1'b0;
                done       = 1'b1;
                div_next   = '0;
                qtr_next   = '0;
                state_next = S_IDLE;
                // busy is already low here, so a pending request is taken at this edge
                if (start) begin
                    accept       = 1'b1;
                    ack_err_next = 1'b0;
                    state_next   = S_START;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_i2c_master_controller.sv
// Bench for i2c_master_controller: two masters (CLK_DIV 4 and 2), each on its own pulled-up bus
// with a clock-sampled behavioural slave at address 0x2A.
module tb_i2c_master_controller;

    logic        clk;
    logic        rst_n;
    logic        start0, start1;
    logic        rw_in;
    logic [6:0]  addr_in;
    logic [31:0] wdata_in;
    logic [31:0] rdata0, rdata1;
    logic        busy0, busy1, done0, done1, ack_err0, ack_err1;
    wire         sda0, scl0, sda1, scl1;

    int checks;
    int failures;

    // slave configuration and observed state
    logic        slv_rst;
    int          nack_byte;
    logic [31:0] rd_data;
    logic [1:0]  slv_low;
    logic [31:0] sreg [2];
    logic [7:0]  abyte [2];
    int          starts [2];
    int          stops [2];
    int          dbits [2];

    typedef struct {
        int          bus;
        logic [6:0]  addr;
        logic        rw;
        logic [31:0] wdata;
        logic [31:0] rd;
        int          nack;
        logic        exp_err;
        int          exp_lat;
        logic [31:0] exp_rdata;
        logic [31:0] exp_sreg;
        int          exp_bits;
    } vec_t;

    vec_t        vt [9];
    logic [31:0] exp_rd [2];
    logic [31:0] exp_sr [2];

    pullup (sda0);
    pullup (scl0);
    pullup (sda1);
    pullup (scl1);
    assign sda0 = slv_low[0] ? 1'b0 : 1'bz;
    assign sda1 = slv_low[1] ? 1'b0 : 1'bz;

    i2c_master_controller #(.CLK_DIV(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .rw(rw_in), .addr(addr_in),
        .wdata(wdata_in), .rdata(rdata0), .busy(busy0), .done(done0),
        .ack_err(ack_err0), .sda(sda0), .scl(scl0)
    );

    i2c_master_controller #(.CLK_DIV(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .rw(rw_in), .addr(addr_in),
        .wdata(wdata_in), .rdata(rdata1), .busy(busy1), .done(done1),
        .ack_err(ack_err1), .sda(sda1), .scl(scl1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Slave model: bus lines sampled on negedge; slot index = number of SCL rises since START
    initial begin
        logic [1:0]  prev_sda, prev_scl;
        logic [31:0] wshift [2];
        logic        active [2];
        logic        match [2];
        logic        rdm [2];
        int          edges [2];
        int          slot, k, byt, pos;
        logic        cs, cl;
        prev_sda = 2'b11;
        prev_scl = 2'b11;
        slv_low  = 2'b00;
        for (int b = 0; b < 2; b++) begin
            wshift[b] = '0; active[b] = 1'b0; match[b] = 1'b0; rdm[b] = 1'b0;
            edges[b] = 0; sreg[b] = '0; abyte[b] = '0;
            starts[b] = 0; stops[b] = 0; dbits[b] = 0;
        end
        forever begin
            @(negedge clk);
            for (int b = 0; b < 2; b++) begin
                cs = (b == 0) ? sda0 : sda1;
                cl = (b == 0) ? scl0 : scl1;
                if (slv_rst) begin
                    active[b] = 1'b0;
                    slv_low[b] = 1'b0;
                    edges[b] = 0;
                end else if (prev_scl[b] && cl && prev_sda[b] && !cs) begin
                    starts[b]++;
                    active[b] = 1'b1;
                    edges[b] = 0;
                    dbits[b] = 0;
                    abyte[b] = '0;
                    match[b] = 1'b0;
                    rdm[b] = 1'b0;
                    slv_low[b] = 1'b0;
                end else if (prev_scl[b] && cl && !prev_sda[b] && cs) begin
                    stops[b]++;
                    active[b] = 1'b0;
                    slv_low[b] = 1'b0;
                end else if (active[b]) begin
                    slot = edges[b];
                    if (!prev_scl[b] && cl) begin
                        if (slot < 8) begin
                            abyte[b] = {abyte[b][6:0], cs};
                        end else if (slot >= 9 && ((slot - 9) % 9) < 8) begin
                            wshift[b] = {wshift[b][30:0], cs};
                        end
                        edges[b]++;
                    end else if (prev_scl[b] && !cl) begin
                        // a completed pulse (rise then fall) in a data slot is one clocked data bit
                        if (slot >= 10 && ((slot - 10) % 9) < 8) dbits[b]++;
                        slv_low[b] = 1'b0;
                        if (slot == 8) begin
                            match[b] = (abyte[b][7:1] == 7'h2A);
                            rdm[b] = abyte[b][0];
                            slv_low[b] = match[b];
                        end else if (slot >= 9 && match[b]) begin
                            k = slot - 9;
                            byt = k / 9;
                            pos = k % 9;
                            if (byt < 4) begin
                                if (pos == 8) begin
                                    if (!rdm[b] && nack_byte != byt + 1) begin
                                        slv_low[b] = 1'b1;
                                        if (byt == 3) sreg[b] = wshift[b];
                                    end
                                end else if (rdm[b]) begin
                                    slv_low[b] = !rd_data[31 - byt * 8 - pos];
                                end
                            end
                        end
                    end
                end
                prev_sda[b] = cs;
                prev_scl[b] = cl;
            end
        end
    end

    function automatic logic busy_of(input int b);
        return (b == 0) ? busy0 : busy1;
    endfunction

    function automatic logic done_of(input int b);
        return (b == 0) ? done0 : done1;
    endfunction

    function automatic logic err_of(input int b);
        return (b == 0) ? ack_err0 : ack_err1;
    endfunction

    function automatic logic [31:0] rdata_of(input int b);
        return (b == 0) ? rdata0 : rdata1;
    endfunction

    task automatic check(input string tag, input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s.%s actual=%0h expected=%0h", tag, name, act, exp);
        end
    endtask

    // Starts counting right after the accept edge; returns the cycle index of done.
    task automatic wait_done(input int b, input logic hold, output int lat, output int bc);
        logic fin;
        fin = 1'b0;
        lat = 0;
        bc = 0;
        while (!fin) begin
            @(negedge clk);
            if (!hold) begin
                start0 = 1'b0;
                start1 = 1'b0;
            end
            lat++;
            if (busy_of(b)) bc++;
            if (done_of(b)) begin
                fin = 1'b1;
            end else if (lat >= 2000) begin
                checks++;
                failures++;
                $display("FAIL timeout bus=%0d waited=%0d cycles required=done", b, lat);
                fin = 1'b1;
            end
        end
    endtask

    // Reference: outcome of one transfer from the protocol rules alone
    task automatic ref_xfer(input int div, input logic [6:0] a, input logic r,
                            input logic [31:0] wd, input logic [31:0] rdd, input int nk,
                            input logic [31:0] old_rdata, input logic [31:0] old_sreg,
                            output logic e_err, output int e_lat, output logic [31:0] e_rdata,
                            output logic [31:0] e_sreg, output int e_bits);
        int quarters;
        e_rdata = old_rdata;
        e_sreg = old_sreg;
        if (a != 7'h2A) begin
            e_err = 1'b1; quarters = 2 + 36 + 3; e_bits = 0;
        end else if (r) begin
            e_err = 1'b0; quarters = 185; e_rdata = rdd; e_bits = 32;
        end else if (nk >= 1 && nk <= 4) begin
            e_err = 1'b1; quarters = 2 + 36 + 36 * nk + 3; e_bits = 8 * nk;
        end else begin
            e_err = 1'b0; quarters = 185; e_sreg = wd; e_bits = 32;
        end
        e_lat = quarters * div + 1;
    endtask

    task automatic do_xfer(input int b, input logic [6:0] a, input logic r,
                           input logic [31:0] wd, input logic [31:0] rdd, input int nk,
                           input logic e_err, input int e_lat, input logic [31:0] e_rdata,
                           input logic [31:0] e_sreg, input int e_bits, input string tag);
        int s0, p0, lat, bc;
        s0 = starts[b];
        p0 = stops[b];
        rd_data = rdd;
        nack_byte = nk;
        @(negedge clk);
        addr_in = a;
        rw_in = r;
        wdata_in = wd;
        if (b == 0) start0 = 1'b1;
        else start1 = 1'b1;
        @(posedge clk);
        wait_done(b, 1'b0, lat, bc);
        check(tag, "latency", lat, e_lat);
        check(tag, "busy_cycles", bc, e_lat - 1);
        check(tag, "ack_err", {31'd0, err_of(b)}, {31'd0, e_err});
        check(tag, "rdata", rdata_of(b), e_rdata);
        check(tag, "slave_reg", sreg[b], e_sreg);
        check(tag, "data_bits", dbits[b], e_bits);
        check(tag, "addr_byte", {24'd0, abyte[b]}, {24'd0, a, r});
        check(tag, "starts", starts[b] - s0, 1);
        check(tag, "stops", stops[b] - p0, 1);
        $display("xfer %s bus=%0d addr=%h rw=%0d wdata=%h lat=%0d ack_err=%0d rdata=%h",
                 tag, b, a, r, wd, lat, err_of(b), rdata_of(b));
        @(negedge clk);
        check(tag, "done_pulse", {31'd0, done_of(b)}, 32'd0);
        check(tag, "idle_busy", {31'd0, busy_of(b)}, 32'd0);
    endtask

    initial begin
        int          lat, bc, s0;
        int          b, nk;
        logic [6:0]  a;
        logic        r, e_err;
        logic [31:0] wd, rdd, e_rdata, e_sreg;
        int          e_lat, e_bits;

        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        addr_in = '0;
        rw_in = 1'b0;
        wdata_in = '0;
        slv_rst = 1'b1;
        nack_byte = 0;
        rd_data = '0;

        vt[0] = '{0, 7'h2A, 1'b0, 32'hDEADBEEF, 32'h0,        0, 1'b0, 741, 32'h0,        32'hDEADBEEF, 32};
        vt[1] = '{0, 7'h2A, 1'b1, 32'h0,        32'hCCAAF0F0, 0, 1'b0, 741, 32'hCCAAF0F0, 32'hDEADBEEF, 32};
        vt[2] = '{0, 7'h15, 1'b0, 32'h12345678, 32'h0,        0, 1'b1, 165, 32'hCCAAF0F0, 32'hDEADBEEF, 0};
        vt[3] = '{0, 7'h2A, 1'b0, 32'h0BADF00D, 32'h0,        1, 1'b1, 309, 32'hCCAAF0F0, 32'hDEADBEEF, 8};
        vt[4] = '{0, 7'h2A, 1'b0, 32'h0BADF00D, 32'h0,        4, 1'b1, 741, 32'hCCAAF0F0, 32'hDEADBEEF, 32};
        vt[5] = '{0, 7'h2A, 1'b1, 32'h0,        32'h13579BDF, 2, 1'b0, 741, 32'h13579BDF, 32'hDEADBEEF, 32};
        vt[6] = '{1, 7'h2A, 1'b0, 32'hDEADBEEF, 32'h0,        0, 1'b0, 371, 32'h0,        32'hDEADBEEF, 32};
        vt[7] = '{1, 7'h2A, 1'b1, 32'h0,        32'hCCAAF0F0, 0, 1'b0, 371, 32'hCCAAF0F0, 32'hDEADBEEF, 32};
        vt[8] = '{1, 7'h15, 1'b1, 32'h0,        32'h55555555, 0, 1'b1, 83,  32'hCCAAF0F0, 32'hDEADBEEF, 0};

        repeat (3) @(negedge clk);
        check("reset", "sda", {31'd0, sda0}, 32'd1);
        check("reset", "scl", {31'd0, scl0}, 32'd1);
        check("reset", "busy", {31'd0, busy0}, 32'd0);
        check("reset", "done", {31'd0, done0}, 32'd0);
        check("reset", "ack_err", {31'd0, ack_err0}, 32'd0);
        check("reset", "rdata", rdata0, 32'd0);
        rst_n = 1'b1;
        slv_rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            do_xfer(vt[i].bus, vt[i].addr, vt[i].rw, vt[i].wdata, vt[i].rd, vt[i].nack,
                    vt[i].exp_err, vt[i].exp_lat, vt[i].exp_rdata, vt[i].exp_sreg,
                    vt[i].exp_bits, $sformatf("vec%0d", i));
        end
        exp_rd[0] = 32'h13579BDF;
        exp_rd[1] = 32'hCCAAF0F0;
        exp_sr[0] = 32'hDEADBEEF;
        exp_sr[1] = 32'hDEADBEEF;

        for (int i = 0; i < 16; i++) begin
            b = int'($urandom_range(0, 1));
            a = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h2A;
            r = 1'($urandom_range(0, 1));
            wd = $urandom;
            rdd = $urandom;
            nk = int'($urandom_range(0, 5));
            if (nk == 5) nk = 0;
            ref_xfer((b == 0) ? 4 : 2, a, r, wd, rdd, nk, exp_rd[b], exp_sr[b],
                     e_err, e_lat, e_rdata, e_sreg, e_bits);
            do_xfer(b, a, r, wd, rdd, nk, e_err, e_lat, e_rdata, e_sreg, e_bits,
                    $sformatf("rnd%0d", i));
            exp_rd[b] = e_rdata;
            exp_sr[b] = e_sreg;
        end

        // start held high across a transfer: ignored while busy, re-accepted at the done edge
        s0 = starts[0];
        nack_byte = 0;
        @(negedge clk);
        addr_in = 7'h15;
        rw_in = 1'b0;
        wdata_in = 32'hA5A5A5A5;
        start0 = 1'b1;
        @(posedge clk);
        wait_done(0, 1'b1, lat, bc);
        check("hold", "latency", lat, 165);
        check("hold", "busy_cycles", bc, 164);
        check("hold", "ack_err", {31'd0, ack_err0}, 32'd1);
        @(posedge clk);
        #1;
        check("hold", "reaccept_busy", {31'd0, busy0}, 32'd1);
        check("hold", "reaccept_ack_err", {31'd0, ack_err0}, 32'd0);
        start0 = 1'b0;
        addr_in = 7'h2A;
        wait_done(0, 1'b0, lat, bc);
        check("hold", "latched_latency", lat, 165);
        check("hold", "latched_ack_err", {31'd0, ack_err0}, 32'd1);
        check("hold", "rdata_kept", rdata0, exp_rd[0]);
        check("hold", "starts", starts[0] - s0, 2);
        $display("xfer hold bus=0 second_lat=%0d ack_err=%0d", lat, ack_err0);
        @(negedge clk);

        // reset during data bit 20 of a write of all zeros (sda and scl both low there)
        @(negedge clk);
        addr_in = 7'h2A;
        rw_in = 1'b0;
        wdata_in = 32'h0;
        start0 = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 506; i++) begin
            @(negedge clk);
            start0 = 1'b0;
        end
        check("midrst", "pre_sda", {31'd0, sda0}, 32'd0);
        check("midrst", "pre_scl", {31'd0, scl0}, 32'd0);
        #1;
        rst_n = 1'b0;
        slv_rst = 1'b1;
        #1;
        check("midrst", "sda", {31'd0, sda0}, 32'd1);
        check("midrst", "scl", {31'd0, scl0}, 32'd1);
        check("midrst", "busy", {31'd0, busy0}, 32'd0);
        check("midrst", "done", {31'd0, done0}, 32'd0);
        check("midrst", "rdata", rdata0, 32'd0);
        $display("xfer midrst bus=0 released sda=%0b scl=%0b", sda0, scl0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        slv_rst = 1'b0;
        @(negedge clk);
        do_xfer(0, 7'h2A, 1'b0, 32'hDEADBEEF, 32'h0, 0, 1'b0, 741, 32'h0, 32'hDEADBEEF, 32,
                "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
